// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int N_REQ = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arb_state_t;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_ADD, OP_SUB} alu_op_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; under contention the requester
// that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between two requesters: accept, launch, wait (with timeout),
// then hand the tagged result back over a valid/ready response channel.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W       = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0][W-1:0]   req_a,
  input  logic [N_REQ-1:0][W-1:0]   req_b,
  input  logic [N_REQ-1:0][1:0]     req_op,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [RW-1:0]             rsp_result,
  output logic                      rsp_err,
  output logic                      alu_start,
  output logic [W-1:0]              alu_a,
  output logic [W-1:0]              alu_b,
  output logic [1:0]                alu_op,
  input  logic                      alu_done,
  input  logic [RW-1:0]             alu_result,
  output logic                      busy,
  output logic                      grant_id,
  output logic [7:0]                timeout_cnt
);

  // Timer runs 0..TIMEOUT-1 across the WAIT cycles; the last value is the timeout cycle.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  arb_state_t    state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          last_grant_reg, last_grant_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  b_reg, b_next;
  alu_op_t       op_reg, op_next;
  logic [15:0]   timer_reg, timer_next;
  logic [RW-1:0] result_reg, result_next;
  logic          err_reg, err_next;
  logic [7:0]    to_cnt_reg, to_cnt_next;

  logic pick_valid;
  logic pick_id;

  rr_pick2 u_pick (
    .req       (req_valid),
    .last      (last_grant_reg),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= OP_AND;
      timer_reg      <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      to_cnt_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      op_reg         <= op_next;
      timer_reg      <= timer_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
      to_cnt_reg     <= to_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    op_next         = op_reg;
    timer_next      = timer_reg;
    result_next     = result_reg;
    err_next        = err_reg;
    to_cnt_next     = to_cnt_reg;
    req_ready       = '0;

    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          req_ready[pick_id] = 1'b1;
          grant_next         = pick_id;
          a_next             = req_a[pick_id];
          b_next             = req_b[pick_id];
          op_next            = alu_op_t'(req_op[pick_id]);
          state_next         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        timer_next = timer_reg + 16'd1;
        // A completion in the timeout cycle still counts as a real result.
        if (alu_done) begin
          result_next = alu_result;
          err_next    = 1'b0;
          state_next  = S_RESP;
        end else if (timer_reg == TIMER_LAST) begin
          result_next = '0;
          err_next    = 1'b1;
          to_cnt_next = (to_cnt_reg != 8'hFF) ? to_cnt_reg + 8'd1 : to_cnt_reg;
          state_next  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[grant_reg]) begin
          last_grant_next = grant_reg;
          state_next      = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_reg == S_RESP) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign rsp_result  = (state_reg == S_RESP) ? result_reg : '0;
  assign rsp_err     = (state_reg == S_RESP) & err_reg;
  assign alu_start   = (state_reg == S_ISSUE);
  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign alu_op      = op_reg;
  assign busy        = (state_reg != S_IDLE);
  assign grant_id    = grant_reg;
  assign timeout_cnt = to_cnt_reg;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed/randomized bench for alu_rr_arbiter with a transaction-level reference model.
module tb_alu_rr_arbiter;

  localparam int TO = 8;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][7:0]  req_a;
  logic [1:0][7:0]  req_b;
  logic [1:0][1:0]  req_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [15:0]      rsp_result;
  logic             rsp_err;
  logic             alu_start;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [1:0]       alu_op;
  logic             alu_done;
  logic [15:0]      alu_result;
  logic             busy;
  logic             grant_id;
  logic [7:0]       timeout_cnt;

  int checks;
  int errors;
  int model_last;
  int exp_to;

  alu_rr_arbiter #(.W(8), .RW(16), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .alu_start   (alu_start),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return {8'h00, a & b};
      2'b01:   return {8'h00, a | b};
      2'b10:   return 16'(a) + 16'(b);
      default: return 16'(a) - 16'(b);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p);
    req_valid[p] = 1'b1;
    req_a[p]     = 8'($urandom);
    req_b[p]     = 8'($urandom);
    req_op[p]    = 2'($urandom);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rsp_valid"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_err"},    32'(rsp_err), 32'd0);
    chk({tag, "_alu_start"},  32'(alu_start), 32'd0);
    chk({tag, "_alu_a"},      32'(alu_a), 32'd0);
    chk({tag, "_alu_b"},      32'(alu_b), 32'd0);
    chk({tag, "_alu_op"},     32'(alu_op), 32'd0);
    chk({tag, "_busy"},       32'(busy), 32'd0);
    chk({tag, "_grant_id"},   32'(grant_id), 32'd0);
    chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'd0);
    chk({tag, "_req_ready"},  32'(req_ready), 32'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    rsp_ready  = '0;
    alu_done   = 1'b0;
    alu_result = '0;
    tick();
    tick();
    chk_idle_zero("reset");
    reset = 1'b1;
    model_last = 1;
    exp_to     = 0;
  endtask

  // Runs one full transaction; requests must already be driven. done_delay is the
  // WAIT cycle (1 = first) in which the ALU answers; 0 means it never answers.
  task automatic transact(input int done_delay, input int hold, input logic [1:0] raise,
                          output int g_out, output logic [15:0] res_out);
    int          g;
    int          exp_g;
    int          lat;
    int          exp_lat;
    bit          timed_out;
    logic [1:0]  v;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [1:0]  eop;
    logic [15:0] exp_res;

    g       = -1;
    g_out   = -1;
    res_out = '0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        break;
      end
      tick();
    end
    chk("accept_seen", 32'(g >= 0), 32'd1);
    if (g < 0) return;

    v = req_valid;
    if (v == 2'b11) exp_g = (model_last == 1) ? 0 : 1;
    else            exp_g = v[1] ? 1 : 0;
    chk("grant", 32'(g), 32'(exp_g));
    chk("req_ready_onehot", 32'(req_ready), 32'(1 << exp_g));
    chk("accept_not_busy", 32'(busy), 32'd0);
    ea  = req_a[exp_g];
    eb  = req_b[exp_g];
    eop = req_op[exp_g];
    timed_out = !(done_delay >= 1 && done_delay <= TO);
    exp_lat   = timed_out ? TO + 1 : done_delay + 1;

    tick();
    req_valid[exp_g] = 1'b0;
    for (int p = 0; p < 2; p++)
      if (raise[p] && !req_valid[p]) set_req(p);
    // A stray completion during the launch cycle must not end the transaction.
    if (timed_out) begin
      alu_done   = 1'b1;
      alu_result = 16'hDEAD;
    end
    #1;
    chk("issue_start", 32'(alu_start), 32'd1);
    chk("issue_grant_id", 32'(grant_id), 32'(exp_g));
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_req_ready", 32'(req_ready), 32'd0);

    lat = 0;
    for (int k = 1; k <= TO + 5; k++) begin
      tick();
      alu_done   = 1'b0;
      alu_result = '0;
      if (rsp_valid != 2'b00) begin
        lat = k;
        break;
      end
      chk("wait_alu_a", 32'(alu_a), 32'(ea));
      chk("wait_alu_b", 32'(alu_b), 32'(eb));
      chk("wait_alu_op", 32'(alu_op), 32'(eop));
      chk("wait_no_start", 32'(alu_start), 32'd0);
      chk("wait_req_ready", 32'(req_ready), 32'd0);
      if (k == done_delay) begin
        alu_done   = 1'b1;
        alu_result = alu_ref(alu_a, alu_b, alu_op);
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));

    if (timed_out) begin
      exp_res = '0;
      if (exp_to < 255) exp_to++;
    end else begin
      exp_res = alu_ref(ea, eb, eop);
    end
    res_out = rsp_result;
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << exp_g));
    chk("rsp_result", 32'(rsp_result), 32'(exp_res));
    chk("rsp_err", 32'(rsp_err), 32'(timed_out));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(exp_to));

    for (int h = 0; h < hold; h++) begin
      rsp_ready[1 - exp_g] = 1'b1;
      tick();
      #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'(1 << exp_g));
      chk("hold_rsp_result", 32'(rsp_result), 32'(exp_res));
      chk("hold_rsp_err", 32'(rsp_err), 32'(timed_out));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready[exp_g] = 1'b1;
    tick();
    rsp_ready  = '0;
    model_last = exp_g;
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    g_out = g;
    $display("txn port=%0d a=%h b=%h op=%0d result=%h err=%0d latency=%0d timeout_cnt=%0d",
             exp_g, ea, eb, eop, res_out, timed_out, lat, timeout_cnt);
  endtask

  initial begin
    int          g;
    logic [15:0] res;
    int          order [4];

    checks = 0;
    errors = 0;
    order  = '{0, 1, 0, 1};

    // Reset state, then a single request on port 0.
    do_reset();
    req_valid  = 2'b01;
    req_a[0]   = 8'h3C;
    req_b[0]   = 8'h0F;
    req_op[0]  = 2'b10;
    transact(2, 0, 2'b00, g, res);
    chk("single_result", 32'(res), 32'h004B);

    // Contention straight after reset: grants alternate starting at port 0.
    do_reset();
    set_req(0);
    set_req(1);
    for (int i = 0; i < 4; i++) begin
      transact(int'($urandom_range(1, 4)), 0, (i < 3) ? 2'(1 << order[i]) : 2'b00, g, res);
      chk("fair_order", 32'(g), 32'(order[i]));
    end
    transact(1, 0, 2'b00, g, res);

    // Back-pressure on port 1 while port 0 waits.
    req_valid = 2'b00;
    set_req(1);
    transact(1, 10, 2'b01, g, res);
    transact(3, 0, 2'b00, g, res);

    // Single timeout, then completion exactly in the timeout cycle.
    set_req(0);
    transact(0, 0, 2'b00, g, res);
    chk("timeout_cnt_one", 32'(timeout_cnt), 32'd1);
    set_req(0);
    transact(TO, 0, 2'b00, g, res);
    chk("coincident_cnt", 32'(timeout_cnt), 32'd1);

    // Reset in the middle of WAIT, followed by a late completion.
    set_req(0);
    #1;
    chk("mw_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    reset      = 1'b1;
    alu_done   = 1'b1;
    alu_result = 16'h1234;
    chk_idle_zero("midwait");
    tick();
    alu_done   = 1'b0;
    alu_result = '0;
    chk_idle_zero("stray_done");
    model_last = 1;
    exp_to     = 0;
    $display("txn reset during WAIT, no response expected");
    set_req(0);
    set_req(1);
    transact(1, 0, 2'b00, g, res);
    chk("post_reset_port", 32'(g), 32'd0);
    transact(2, 0, 2'b00, g, res);

    // Saturation of the timeout counter.
    for (int i = 0; i < 300; i++) begin
      set_req(int'($urandom_range(0, 1)));
      transact(0, int'($urandom_range(0, 2)), 2'b00, g, res);
    end
    chk("timeout_saturated", 32'(timeout_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares the single ALU datapath (8-bit operands A/B, 2-bit op, 16-bit result) between two requesters. Typical requesters are the interactive LFSR/button controller (port 0) and a self-test sequencer (port 1). The block accepts one request at a time and latches its operands. It issues a one-cycle start to the ALU, waits for completion or a timeout, then returns the tagged result to the winning requester with a valid/ready handshake.

## Interface
- `W`, 8, operand width
- `RW`, 16, result width
- `TIMEOUT`, 255, maximum cycles to wait for `alu_done` after `alu_start` (1..65535)

- `clk`  in  1  system clock (10 MHz domain)
- `reset`  in  1  synchronous, active-low reset
- `req_valid`  in  2  request valid, one bit per requester
- `req_ready`  out  2  request accepted, one-hot or zero
- `req_a` / `req_b`  in  2×W  operands per requester
- `req_op`  in  2×2  op per requester: 00 AND, 01 OR, 10 ADD, 11 SUB
- `rsp_valid`  out  2  response valid per requester
- `rsp_ready`  in  2  response consumed per requester
- `rsp_result`  out  RW  result, shared bus, meaningful for the bit set in `rsp_valid`
- `rsp_err`  out  1  response is a timeout (`rsp_result`=0)
- `alu_start`  out  1  one-cycle launch pulse
- `alu_a` / `alu_b`  out  W  latched operands, stable from ISSUE through WAIT
- `alu_op`  out  2  latched op
- `alu_done`  in  1  ALU completion strobe
- `alu_result`  in  RW  ALU result, valid with `alu_done`
- `busy`  out  1  state ≠ IDLE
- `grant_id`  out  1  requester owning the current transaction
- `timeout_cnt`  out  8  saturating count of timeouts

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If any `req_valid` is set, pick the winner `g`.
  - If both are valid, the winner is the requester ≠ `last_grant`.
  - `req_ready[g]`=1 combinationally in that cycle; A, B, op and `g` are latched; go to ISSUE.
- ISSUE: `alu_start`=1 for exactly one cycle; clear the timeout counter; go to WAIT. `alu_done` in this cycle is ignored.
- WAIT:
  - Timer increments each cycle.
  - On `alu_done`: latch `alu_result`, `rsp_err`=0, go to RESP.
  - When the timer reaches `TIMEOUT` without `alu_done`: result=0, `rsp_err`=1, `timeout_cnt` increments (saturates at 255), go to RESP.
  - If `alu_done` and timeout occur in the same cycle, `alu_done` wins.
- RESP:
  - `rsp_valid[g]`=1 and held, with `rsp_result`/`rsp_err` stable, until `rsp_ready[g]`.
  - On handshake: `last_grant`←`g`, go to IDLE.
- `alu_done` outside WAIT is ignored. It does not alter the state or any counter.
- Requests are never dropped. An un-granted `req_valid` waits. Requesters must hold operands stable until `req_ready`.
- Operand widths are passed unchanged. The block performs no arithmetic on data.

## Timing
- Reset (`reset`=0 at a rising edge):
  - State goes to IDLE; all outputs 0, including `timeout_cnt`.
  - `last_grant`=1, so requester 0 wins the first contention.
  - An in-flight transaction is discarded and no response is issued.
- Minimum latency:
  - Accept at cycle N; `alu_start` at N+1.
  - Earliest `alu_done` is N+2; `rsp_valid` is then N+3.
  - With `rsp_ready` already high, the handshake completes at N+3 and the next accept is at N+4.
- Timeout: `alu_start` at cycle S with no `alu_done` → `rsp_valid` at S+TIMEOUT+1.
- `req_ready` is never asserted outside IDLE. At most one bit of `req_ready` and of `rsp_valid` is set.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Structure
- Package `alu_arb_pkg`:
  - `arb_state_t` enum {S_IDLE, S_ISSUE, S_WAIT, S_RESP}
  - `alu_op_t` enum {OP_AND, OP_OR, OP_ADD, OP_SUB}
  - constant `N_REQ`=2
- Sub-module `rr_pick2`: combinational 2-way round-robin picker with inputs `req[1:0]` and `last` and outputs `gnt_valid` and `gnt_id`. `last_grant` is kept in the parent.

## Test plan
- Single request: port 0 sends A=8'h3C, B=8'h0F, op=10; ALU model returns 16'h004B two cycles after start → `alu_a`=3C/`alu_b`=0F/`alu_op`=10 during WAIT; `rsp_valid[0]` with `rsp_result`=004B, `rsp_err`=0; `rsp_valid[1]`=0.
- Contention after reset: both ports valid in the same cycle → grant order 0,1,0,1 over four transactions. `req_ready` is one-hot and only in IDLE.
- Timeout: `TIMEOUT`=8, ALU never responds → `rsp_valid` 9 cycles after `alu_start` with `rsp_err`=1, `rsp_result`=0, `timeout_cnt`=1. After 300 timeouts, `timeout_cnt`=255.
- Back-pressure: hold `rsp_ready[1]`=0 for 10 cycles → `rsp_valid[1]` and `rsp_result` stay stable, and no new `req_ready` is issued to port 0 despite a pending request.
- Reset mid-WAIT: assert `reset`=0 one cycle after `alu_start`, then deliver a late `alu_done` → no `rsp_valid`, state IDLE, all outputs 0, stray `alu_done` ignored. The next request is served normally by port 0.
- `alu_done` coincident with the timeout cycle → `rsp_err`=0, ALU result returned, `timeout_cnt` unchanged.
